// File: rtl/tinyriscv_pkg.sv
// Shared types and constants for the instruction prefetch path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the prefetch FSM state enum and the per-instruction address step.
package tinyriscv_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2
    } pf_state_e;

    // Byte distance between consecutive 32-bit instructions.
    localparam int INSTR_STEP = 4;

endpackage

// File: rtl/prefetch_fifo.sv
// Generic circular buffer holding prefetched {address, instruction} entries.
// Latency: a pushed entry is visible on rdata_o the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored; the caller gates them.
//
// Ports: clk_i/rst_ni clock and async active-low reset; clear_i synchronous flush
// (wins over push/pop); push_i/wdata_i write side; pop_i read side; rdata_o head
// entry; count_o occupancy 0..DEPTH; full_o/empty_o status.
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [PW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem[rptr_q];
    assign count_o = count_q;

    // Pointers are exactly log2(DEPTH) bits so they wrap on their own.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PW'(1);
            if (do_pop)  rptr_q <= rptr_q + PW'(1);
            count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    // Storage needs no reset: the head is only observed while count_q != 0.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: sequential fetches into a small buffer, with redirect and halt.
// Latency: fetched word visible on valid_o the next cycle (same cycle with PREFETCH_BYPASS_EN and empty buffer).
// Backpressure: stops requesting when the buffer is full or halt_i is high; jump_flag_i flushes everything.
//
// Ports: clk_i/rst_ni clock and async active-low reset; instr_req_o/instr_addr_o/
// instr_ready_i/instr_rdata_i fetch interface (one request in flight, address held
// until ready); jump_flag_i/jump_addr_i redirect; halt_i stops new fetches;
// valid_o/ready_i/instr_o/pc_o/pc_next_o consumer side; count_o buffer occupancy.
// Optional macro PREFETCH_BYPASS_EN forwards a completing fetch straight to the
// consumer when the buffer is empty.
module prefetch_unit
    import tinyriscv_pkg::*;
#(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    output logic                     instr_req_o,
    output logic [ADDR_W-1:0]        instr_addr_o,
    input  logic                     instr_ready_i,
    input  logic [DATA_W-1:0]        instr_rdata_i,
    input  logic                     jump_flag_i,
    input  logic [ADDR_W-1:0]        jump_addr_i,
    input  logic                     halt_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [DATA_W-1:0]        instr_o,
    output logic [ADDR_W-1:0]        pc_o,
    output logic [ADDR_W-1:0]        pc_next_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    pf_state_e                  state_q, state_d;
    logic [ADDR_W-1:0]          fetch_addr_q;
    logic [DATA_W+ADDR_W-1:0]   head;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       fire;
    logic                       bypass;
    logic                       push;
    logic                       pop;

    assign instr_req_o  = (state_q == FETCH) && !fifo_full && !jump_flag_i;
    assign instr_addr_o = fetch_addr_q;
    assign fire         = instr_req_o && instr_ready_i;

`ifdef PREFETCH_BYPASS_EN
    assign bypass = fire && fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    // fire already excludes a redirect cycle, so a response arriving then is dropped.
    assign valid_o = !jump_flag_i && (!fifo_empty || bypass);
    assign pop     = !jump_flag_i && !fifo_empty && ready_i;
    // A bypassed word the consumer takes immediately never enters the buffer.
    assign push    = fire && !(bypass && ready_i);

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + ADDR_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (jump_flag_i),
        .push_i  (push),
        .wdata_i ({fetch_addr_q, instr_rdata_i}),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Outputs read as zero whenever nothing is presented, which also covers reset.
    always_comb begin
        instr_o = '0;
        pc_o    = '0;
        if (valid_o) begin
            if (bypass) begin
                instr_o = instr_rdata_i;
                pc_o    = fetch_addr_q;
            end else begin
                instr_o = head[DATA_W-1:0];
                pc_o    = head[DATA_W +: ADDR_W];
            end
        end
    end

    assign pc_next_o = valid_o ? (pc_o + ADDR_W'(INSTR_STEP)) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= BOOT;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (jump_flag_i) begin
            state_d = FETCH;
        end else begin
            unique case (state_q)
                BOOT: state_d = FETCH;
                FETCH: begin
                    // A request already on the bus must finish before halting.
                    if (halt_i && !(instr_req_o && !instr_ready_i)) state_d = STALL;
                    else if (fifo_full && !pop)                     state_d = STALL;
                end
                STALL: begin
                    // A pop this cycle frees a slot, so resume without an idle cycle.
                    if (!halt_i && (!fifo_full || pop)) state_d = FETCH;
                end
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_addr_q <= BOOT_ADDR;
        end else if (jump_flag_i) begin
            fetch_addr_q <= {jump_addr_i[ADDR_W-1:2], 2'b00};
        end else if (fire) begin
            fetch_addr_q <= fetch_addr_q + ADDR_W'(INSTR_STEP);
        end
    end

endmodule

// File: tb/tb_prefetch_unit.sv
// Self-checking bench for prefetch_unit: directed scenarios then randomized traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_prefetch_unit;

    localparam int DEPTH = 4;

    logic        clk_i;
    logic        rst_ni;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_ready_i;
    logic [31:0] instr_rdata_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        halt_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_next_o;
    logic [2:0]  count_o;

    prefetch_unit dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .instr_req_o   (instr_req_o),
        .instr_addr_o  (instr_addr_o),
        .instr_ready_i (instr_ready_i),
        .instr_rdata_i (instr_rdata_i),
        .jump_flag_i   (jump_flag_i),
        .jump_addr_i   (jump_addr_i),
        .halt_i        (halt_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_next_o     (pc_next_o),
        .count_o       (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of buffered {addr, data} entries, the next fetch
    // address, and the controller mode (0 boot, 1 fetching, 2 stalled).
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    int          mmode;
    logic [31:0] maddr;
    logic [31:0] dut_fires[$];

    task automatic model_reset();
        mq.delete();
        mmode = 0;
        maddr = 32'h0;
    endtask

    // One clock cycle: drive inputs, compare every output with the model,
    // advance the model, then move to just after the next rising edge.
    task automatic cycle(input logic ir, input logic rd, input logic h, input logic j,
                         input logic [31:0] ja, input logic [31:0] data);
        logic full, ereq, efire, ebyp, evalid, epop;
        logic [31:0] ei, ep;
        ent_t e;
        instr_ready_i = ir;
        ready_i       = rd;
        halt_i        = h;
        jump_flag_i   = j;
        jump_addr_i   = ja;
        instr_rdata_i = data;
        #1;
        full  = (mq.size() == DEPTH);
        ereq  = (mmode == 1) && !full && !j;
        efire = ereq && ir;
        ebyp  = 1'b0;
`ifdef PREFETCH_BYPASS_EN
        ebyp  = efire && (mq.size() == 0);
`endif
        evalid = !j && ((mq.size() > 0) || ebyp);
        ei = 32'h0;
        ep = 32'h0;
        if (evalid) begin
            if (ebyp) begin
                ei = data;
                ep = maddr;
            end else begin
                ei = mq[0].d;
                ep = mq[0].a;
            end
        end
        chk("req",     instr_req_o,  ereq);
        chk("addr",    instr_addr_o, maddr);
        chk("valid",   valid_o,      evalid);
        chk("instr",   instr_o,      ei);
        chk("pc",      pc_o,         ep);
        chk("pc_next", pc_next_o,    evalid ? ep + 32'd4 : 32'h0);
        chk("count",   count_o,      mq.size());
        if (instr_req_o && instr_ready_i) dut_fires.push_back(instr_addr_o);

        epop = !j && (mq.size() > 0) && rd;
        if (j) begin
            mq.delete();
            maddr = {ja[31:2], 2'b00};
            mmode = 1;
        end else begin
            case (mmode)
                0: mmode = 1;
                1: if ((h && !(ereq && !ir)) || (full && !epop)) mmode = 2;
                default: if (!h && (!full || epop)) mmode = 1;
            endcase
            if (epop) void'(mq.pop_front());
            if (efire && !(ebyp && rd)) begin
                e.a = maddr;
                e.d = data;
                mq.push_back(e);
            end
            if (efire) maddr = maddr + 32'd4;
        end
        @(posedge clk_i);
        #1;
    endtask

    // Reset asserted mid-cycle with a response offered: everything must read zero.
    task automatic do_reset();
        rst_ni        = 1'b0;
        instr_ready_i = 1'b1;
        ready_i       = 1'b1;
        halt_i        = 1'b0;
        jump_flag_i   = 1'b0;
        #1;
        chk("rst_req",     instr_req_o, 0);
        chk("rst_valid",   valid_o,     0);
        chk("rst_count",   count_o,     0);
        chk("rst_instr",   instr_o,     0);
        chk("rst_pc",      pc_o,        0);
        chk("rst_pc_next", pc_next_o,   0);
        chk("rst_addr",    instr_addr_o, 32'h0);
        @(posedge clk_i);
        #1;
        chk("rst_req_hold", instr_req_o, 0);
        rst_ni = 1'b1;
        model_reset();
    endtask

    logic hold_h;

    initial begin
        rst_ni        = 1'b0;
        instr_ready_i = 1'b0;
        instr_rdata_i = 32'h0;
        jump_flag_i   = 1'b0;
        jump_addr_i   = 32'h0;
        halt_i        = 1'b0;
        ready_i       = 1'b0;
        hold_h        = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        do_reset();

        // Boot: responses always ready, consumer idle -> four fetches then full.
        dut_fires.delete();
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 0, $urandom);
        chk("boot_nfires", dut_fires.size(), 4);
        for (int i = 0; i < 4; i++) chk("boot_fire_addr", dut_fires[i], 32'(i * 4));
        chk("boot_count", count_o, 4);
        chk("boot_req_low", instr_req_o, 0);

        // Backpressure: single pop from full, one refetch at 0x10.
        cycle(1, 1, 0, 0, 0, $urandom);
        cycle(1, 0, 0, 0, 0, $urandom);
        instr_ready_i = 1'b0;
        #1;
        chk("bp_fire_addr", dut_fires[$], 32'h10);
        chk("bp_count", count_o, 4);
        cycle(0, 0, 0, 0, 0, $urandom);

        // Flush with a response in the same cycle.
        cycle(0, 1, 0, 0, 0, $urandom);
        chk("flush_pre_count", count_o, 3);
        cycle(1, 0, 0, 1, 32'h103, 32'hDEAD_BEEF);
        jump_flag_i   = 1'b0;
        instr_ready_i = 1'b0;
        #1;
        chk("flush_addr", instr_addr_o, 32'h100);
        chk("flush_count", count_o, 0);

        // Wait states: three idle cycles then the response.
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, $urandom);
        cycle(1, 0, 0, 0, 0, $urandom);
        chk("ws_count", count_o, 1);

        // Halt raised while a request is pending.
        cycle(0, 0, 1, 0, 0, $urandom);
        cycle(0, 0, 1, 0, 0, $urandom);
        cycle(1, 0, 1, 0, 0, $urandom);
        cycle(1, 0, 1, 0, 0, $urandom);
        cycle(1, 0, 1, 0, 0, $urandom);
        chk("halt_req_low", instr_req_o, 0);
        cycle(0, 0, 0, 0, 0, $urandom);

        // Empty buffer, response 0x13 at 0x20.
        cycle(0, 0, 0, 1, 32'h20, $urandom);
        cycle(1, 0, 0, 0, 0, 32'h0000_0013);
        instr_ready_i = 1'b0;
        #1;
        chk("byp_valid",   valid_o,   1);
        chk("byp_instr",   instr_o,   32'h13);
        chk("byp_pc",      pc_o,      32'h20);
        chk("byp_pc_next", pc_next_o, 32'h24);

        // Randomized traffic with one reset in the middle.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            if ($urandom_range(0, 99) < 5) hold_h = !hold_h;
            cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50, hold_h,
                  $urandom_range(0, 99) < 4, $urandom, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction buffer entries (power of two, >=2).
REQ-002 SHALL have parameter ADDR_W, default 32, fetch address width.
REQ-003 SHALL have parameter DATA_W, default 32, instruction width.
REQ-004 SHALL have parameter BOOT_ADDR, default 32'h0000_0000, first fetch address after reset.
REQ-005 SHALL have clock and reset ports clk_i and rst_ni; one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- instr_req_o  out  1  fetch request
- instr_addr_o  out  ADDR_W  fetch address
- instr_ready_i  in  1  fetch complete; instr_rdata_i is valid this cycle
- instr_rdata_i  in  DATA_W  fetched word
- jump_flag_i  in  1  redirect/flush
- jump_addr_i  in  ADDR_W  redirect target
- halt_i  in  1  stop issuing new fetches
- valid_o  out  1  instruction available
- ready_i  in  1  consumer accepts
- instr_o  out  DATA_W  instruction
- pc_o  out  ADDR_W  its address
- pc_next_o  out  ADDR_W  pc_o + 4
- count_o  out  $clog2(DEPTH)+1  occupancy

Function
REQ-006 SHALL complete a fetch in any cycle where instr_req_o && instr_ready_i, with at most one request in flight.
REQ-007 SHALL hold instr_addr_o stable while instr_req_o is high and instr_ready_i is low.
REQ-008 SHALL assert instr_req_o only in state FETCH with registered count < DEPTH and no jump_flag_i.
REQ-009 SHALL advance the fetch address by 4 (modulo 2^ADDR_W, wrap permitted) on each completed fetch.
REQ-010 SHALL pop one entry when valid_o && ready_i.
REQ-011 SHALL not push a completed fetch into a full buffer; instr_req_o is low while count == DEPTH, so a pop while full allows a push only from the next cycle.
REQ-012 SHALL implement FSM states BOOT, FETCH and STALL.
- BOOT: entered on reset; goes to FETCH after one cycle.
- FETCH -> STALL when halt_i, or when full and no pop.
- STALL -> FETCH when !halt_i and not full.
- Any state -> FETCH on jump_flag_i.
REQ-013 SHALL handle jump_flag_i as follows.
- Clear the buffer (count 0) at the next edge.
- Load the fetch address with {jump_addr_i[ADDR_W-1:2], 2'b00}.
- Force valid_o and instr_req_o low that cycle.
- Discard any response that arrives in that cycle.
REQ-014 SHALL give jump_flag_i priority over halt_i, push and pop in the same cycle.
REQ-015 SHALL, on halt_i, let a request already raised complete (REQ-007) before deasserting instr_req_o.
REQ-016 SHALL drive pc_next_o = pc_o + 4 truncated to ADDR_W.
REQ-017 SHALL use read/write pointers of $clog2(DEPTH) bits that wrap naturally, with count tracking 0..DEPTH.

Reset
REQ-018 SHALL, while rst_ni is low, hold the following values.
- instr_req_o = 0, valid_o = 0, count_o = 0.
- instr_o, pc_o and pc_next_o = 0.
- Pointers = 0, state = BOOT, fetch address = BOOT_ADDR.
REQ-019 SHALL, on reset asserted mid-transfer, drop the pending request and ignore instr_ready_i until BOOT exits.

Configuration
REQ-020 SHALL support macro PREFETCH_BYPASS_EN, which controls buffer-empty forwarding.
- Defined: with the buffer empty and a fetch completing, valid_o = 1 the same cycle with instr_rdata_i on instr_o. If ready_i is also high, the word is consumed and not stored.
- Undefined: every instruction passes through the buffer, so valid_o rises no earlier than the cycle after completion.

Structure
REQ-021 SHALL take the FSM state enum (pf_state_e) and the instruction step constant (INSTR_STEP = 4) from tinyriscv_pkg.
REQ-022 SHALL place the buffer storage in one sub-module, prefetch_fifo, parametrised by DEPTH and a width of DATA_W+ADDR_W, with a synchronous clear input.

Verification
REQ-023 Boot: reset release, instr_ready_i tied 1, ready_i 0 -> fetch addresses 0x0, 0x4, 0x8, 0xC; count_o reaches 4 (DEPTH = 4); instr_req_o then low.
REQ-024 Backpressure: full buffer, ready_i pulsed for 1 cycle -> count_o 4 -> 3, one new fetch at 0x10 on the following cycle, count_o back to 4.
REQ-025 Flush: count_o = 3, jump_flag_i with jump_addr_i = 0x103 and an instr_ready_i response in the same cycle -> response discarded, count_o = 0, next instr_addr_o = 0x100.
REQ-026 Wait states: instr_ready_i low for 3 cycles -> instr_addr_o and instr_req_o stable for those cycles; the word is pushed on the 4th cycle.
REQ-027 Halt: halt_i raised during a pending request -> that request completes, then instr_req_o stays 0 until halt_i falls.
REQ-028 Bypass, PREFETCH_BYPASS_EN on versus off: buffer empty and response 0x00000013 at 0x20 -> valid_o in the same cycle (on) versus the next cycle (off), with pc_o = 0x20 and pc_next_o = 0x24.
